mux_sel_scanner: RTL
====================

Name: mux_sel_scanner

Overview:
- Sequencer that sits directly upstream of the 4-to-1 key-select mux (the `example` instance).
- Drives the mux select key round-robin, holding each channel for a programmable dwell, and samples the mux output f at the end of each dwell.
- After a full sweep, publishes all channel values as one packed snapshot over a valid/ready handshake.
- Replaces hand-driven select lines and the free-running rotate counter in bring-up benches.

Parameters:
- NR_CH, 4, number of mux channels swept; SEL_LEN = clog2(NR_CH), 2 at default.
- DATA_LEN, 2, width of the mux output f and of each snapshot field.
- DWELL, 5, cycles each channel is held before sampling; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  sweep enable, level-sensitive.
- sel  out  SEL_LEN  select key to the mux (its y input).
- mux_in  in  DATA_LEN  mux output f.
- snap  out  NR_CH*DATA_LEN  snapshot; channel k occupies [DATA_LEN*(k+1)-1 : DATA_LEN*k].
- snap_valid  out  1  snapshot available.
- snap_ready  in  1  consumer accepts the snapshot.
- busy  out  1  sweep in progress.
- overrun  out  1  sticky; a completed sweep was dropped.
- clr_ovr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately): sel=0, snap=0, snap_valid=0, busy=0, overrun=0. Dwell counter, channel index and shadow registers are cleared; state=IDLE.
- States: IDLE, SCAN.
- IDLE:
  - sel=0, busy=0.
  - en=1 sampled at edge E0 → SCAN with ch=0, cnt=0.
- SCAN:
  - busy=1, sel=ch.
  - Each edge: cnt increments.
  - When cnt==DWELL-1: shadow[ch]<=mux_in, cnt<=0, ch<=ch+1.
  - Final channel (ch==NR_CH-1): on its capture edge, snap<={mux_in, shadow[NR_CH-2:0]} and snap_valid<=1.
  - ch wraps to 0 and scanning continues while en=1.
- Latency: first snap_valid is high after edge E(NR_CH*DWELL); 20 cycles at defaults. DWELL=1 captures every cycle.
- en=0 sampled in SCAN: abort at that edge → IDLE, sel=0, partial shadow discarded. snap and snap_valid are unaffected.
- Handshake:
  - Transfer occurs on an edge with snap_valid&snap_ready.
  - snap_valid falls after the transfer unless a sweep completes on the same edge; then snap takes the new data and snap_valid stays 1.
  - snap is stable while snap_valid=1 and no transfer occurs.
- Overrun:
  - A sweep completes while snap_valid=1 and snap_ready=0: the new data is dropped, snap keeps the old value, overrun<=1. Scanning continues.
  - overrun is cleared by clr_ovr=1 at an edge. If a set and clr_ovr occur on the same edge, set wins.
- Width rules:
  - cnt width is clog2(DWELL) bits (minimum 1); ch width is SEL_LEN.
  - ch wrap uses explicit compare with NR_CH-1, so non-power-of-2 NR_CH never drives out-of-range sel.

Optional Feature:
- Macro: MUX_SCAN_MASK_EN.
- Defined:
  - Adds port ch_mask in NR_CH; bit k=1 scans channel k. Mask is sampled at each sweep start (entry to channel 0 position).
  - Masked channels are skipped with zero dwell cycles; their snap fields are 0.
  - Sweep length = popcount(mask)*DWELL.
  - All-zero mask: stay in IDLE, busy=0, no snapshot.
- Undefined: no ch_mask port; all NR_CH channels scanned every sweep.

Test Plan:
- Defaults; mux inputs x0=1, x1=2, x2=3, x3=0; en=1 held, snap_ready=1 → sel steps 0,1,2,3 each held 5 cycles. snap=8'h39 with a 1-cycle snap_valid pulse 20 cycles after en sampled, repeating every 20 cycles.
- snap_ready=0 for 45 cycles → first snap 8'h39 held stable; second sweep dropped and overrun=1 at cycle 40. Assert clr_ovr → overrun=0 next cycle.
- Change x1 to 0 during sweep 2 with snap_ready=1 → second snap=8'h31. On the edge where sweep 2 completes, snap_ready=1 and snap_valid stays high.
- en dropped at cycle 12 (mid-channel 2) → sel=0 and busy=0 next cycle, no snap_valid. Re-enable → full 20-cycle sweep before the next snap.
- DWELL=1 → sel changes every cycle, snap_valid every 4 cycles. rst pulled low mid-sweep → all outputs 0 immediately without waiting for clk.
- MUX_SCAN_MASK_EN, ch_mask=4'b1010 → sel visits only 1 and 3; snap=8'h08 (x3=0, x1=2) after 10 cycles. Mask 4'b0000 → busy stays 0.

Source files
------------

// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner: round-robin select sequencer that sweeps the key-select mux and publishes packed snapshots.
// Optional build macro MUX_SCAN_MASK_EN adds ch_mask_i so that masked channels are skipped and read as zero.
module mux_sel_scanner #(
  parameter  int NR_CH    = 4,
  parameter  int DATA_LEN = 2,
  parameter  int DWELL    = 5,
  localparam int SEL_LEN  = (NR_CH > 1) ? $clog2(NR_CH) : 1,
  localparam int CNT_LEN  = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  output logic [SEL_LEN-1:0]        sel_o,
  input  logic [DATA_LEN-1:0]       mux_in_i,
  output logic [NR_CH*DATA_LEN-1:0] snap_o,
  output logic                      snap_valid_o,
  input  logic                      snap_ready_i,
  output logic                      busy_o,
  output logic                      overrun_o,
`ifdef MUX_SCAN_MASK_EN
  input  logic [NR_CH-1:0]          ch_mask_i,
`endif
  input  logic                      clr_ovr_i
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t                         state_q, state_d;
  logic [SEL_LEN-1:0]             ch_q, ch_d, first_ch, next_ch;
  logic [CNT_LEN-1:0]             cnt_q, cnt_d;
  logic [NR_CH-1:0][DATA_LEN-1:0] shadow_q, shadow_d, snap_q, snap_d, sweep;
  logic                           valid_q, valid_d, ovr_q, ovr_d;
  logic [NR_CH-1:0]               scan_mask;
  logic                           any_live, last_ch, dwell_end, done;

`ifdef MUX_SCAN_MASK_EN
  logic [NR_CH-1:0] mask_q, mask_d;
  assign scan_mask = mask_q;
  assign any_live  = |ch_mask_i;
  // The live mask is tracked while idle and re-captured on the edge that ends a sweep, so it holds for a whole sweep
  assign mask_d = (state_q == IDLE || (dwell_end && last_ch)) ? ch_mask_i : mask_q;
  // Sweep mask register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mask_q <= '0;
    else mask_q <= mask_d;
  end
  // First enabled channel of the live mask, and next enabled channel above ch_q in the sweep mask
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    last_ch  = 1'b1;
    for (int k = NR_CH - 1; k >= 0; k--) begin
      if (ch_mask_i[k]) first_ch = SEL_LEN'(k);
      if (scan_mask[k] && k > int'(ch_q)) begin
        next_ch = SEL_LEN'(k);
        last_ch = 1'b0;
      end
    end
  end
`else
  assign scan_mask = '1;
  assign any_live  = 1'b1;
  assign first_ch  = '0;
  assign last_ch   = ch_q == SEL_LEN'(NR_CH - 1);
  assign next_ch   = ch_q + SEL_LEN'(1);
`endif

  assign dwell_end    = cnt_q == CNT_LEN'(DWELL - 1);
  assign sel_o        = (state_q == SCAN) ? ch_q : '0;
  assign busy_o       = state_q == SCAN;
  assign snap_o       = snap_q;
  assign snap_valid_o = valid_q;
  assign overrun_o    = ovr_q;

  // Completed-sweep image: the channel captured this edge comes straight from the mux, masked channels read zero
  always_comb begin
    sweep = '0;
    for (int k = 0; k < NR_CH; k++)
      sweep[k] = !scan_mask[k] ? '0 : (k == int'(ch_q)) ? mux_in_i : shadow_q[k];
  end

  // Sequencing, capture, snapshot hand-off and sticky overrun; an overrun set beats a same-edge clear
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    snap_d   = snap_q;
    valid_d  = valid_q && !snap_ready_i;
    ovr_d    = ovr_q && !clr_ovr_i;
    done     = 1'b0;
    if (state_q == IDLE) begin
      if (en_i && any_live) begin
        state_d  = SCAN;
        ch_d     = first_ch;
        cnt_d    = '0;
        shadow_d = '0;
      end
    end else if (!en_i) begin
      state_d  = IDLE;
      ch_d     = '0;
      cnt_d    = '0;
      shadow_d = '0;
    end else if (!dwell_end) begin
      cnt_d = cnt_q + CNT_LEN'(1);
    end else begin
      cnt_d          = '0;
      shadow_d[ch_q] = mux_in_i;
      ch_d           = next_ch;
      if (last_ch) begin
        done     = 1'b1;
        shadow_d = '0;
        ch_d     = first_ch;
        state_d  = any_live ? SCAN : IDLE;
      end
    end
    if (done) begin
      if (!valid_q || snap_ready_i) begin
        snap_d  = sweep;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      snap_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      snap_q   <= snap_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end
endmodule
